// File: rtl/timer_scheduler.sv
// -----------------------------------------------------------------------------
// timer_scheduler
//
// Round-robin arbiter that shares one interval counter among NUM_REQ
// requesters. The winner's terminal count is latched. The counter then advances
// on clock_enable ticks until it reaches that count. The owner then gets a
// one-cycle done pulse.
//
// Ports
//   clock         in   system clock, rising edge
//   sync_reset    in   synchronous active-high reset, highest priority
//   clock_enable  in   tick qualifier for the interval counter
//   req_valid     in   [NUM_REQ]            per-requester request
//   req_length    in   [NUM_REQ*CNT_WIDTH]  per-requester terminal count
//   req_ready     out  [NUM_REQ]            one-hot accept (combinational)
//   done          out  [NUM_REQ]            one-cycle completion pulse (registered)
//   busy          out                       high in RUN or DONE
//   grant_id      out  [$clog2(NUM_REQ)]    current / most recent owner
// -----------------------------------------------------------------------------
module timer_scheduler #(
  parameter int NUM_REQ   = 4,
  parameter int CNT_WIDTH = 16,
  localparam int IDW      = $clog2(NUM_REQ)
) (
  input  logic                          clock,
  input  logic                          sync_reset,
  input  logic                          clock_enable,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*CNT_WIDTH-1:0]  req_length,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            done,
  output logic                          busy,
  output logic [IDW-1:0]                grant_id
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   count_q, count_d;
  logic [CNT_WIDTH-1:0]   len_q, len_d;
  logic [IDW-1:0]         grant_q, grant_d;
  logic [IDW-1:0]         last_q, last_d;
  logic [NUM_REQ-1:0]     done_q, done_d;

  // Unpacked view of the flat length bus so the winner's field is a plain index.
  logic [CNT_WIDTH-1:0]   len_arr [NUM_REQ];
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_len
    assign len_arr[g] = req_length[g*CNT_WIDTH +: CNT_WIDTH];
  end

  // Round-robin search: start one past the last owner and wrap.
  logic           sel_found;
  logic [IDW-1:0] sel_idx;

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!sel_found && req_valid[idx]) begin
        sel_found = 1'b1;
        sel_idx   = IDW'(idx);
      end
    end
  end

  // Accept only in IDLE; reset forces it low so a same-cycle transfer is lost.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && sel_found && !sync_reset) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    grant_d = grant_q;
    last_d  = last_q;
    done_d  = '0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_found) begin
          len_d   = len_arr[sel_idx];
          count_d = '0;
          grant_d = sel_idx;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Compare before incrementing, so an all-ones length ends without wrap.
        if (clock_enable) begin
          if (count_q == len_q) begin
            state_d         = S_DONE;
            done_d[grant_q] = 1'b1;
          end else begin
            count_d = count_q + CNT_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (sync_reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      len_q   <= '0;
      grant_q <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign done     = done_q;
  assign busy     = (state_q != S_IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// -----------------------------------------------------------------------------
// tb_timer_scheduler
//
// Directed bench for timer_scheduler. Inputs for cycle c are driven at the
// falling edge inside that cycle, and outputs are sampled 1 ns later. The
// default instance (CNT_WIDTH=16) covers arbitration, tick gating, reset and
// input isolation. A CNT_WIDTH=4 instance covers the all-ones length.
// -----------------------------------------------------------------------------
module tb_timer_scheduler;

  logic        clock = 1'b0;
  logic        sync_reset = 1'b1;
  logic        clock_enable = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [63:0] req_length = '0;
  logic [3:0]  req_ready;
  logic [3:0]  done;
  logic        busy;
  logic [1:0]  grant_id;

  logic [3:0]  req_valid_s = '0;
  logic [15:0] req_length_s = '0;
  logic [3:0]  req_ready_s;
  logic [3:0]  done_s;
  logic        busy_s;
  logic [1:0]  grant_id_s;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  timer_scheduler #(.NUM_REQ(4), .CNT_WIDTH(16)) dut (
    .clock(clock), .sync_reset(sync_reset), .clock_enable(clock_enable),
    .req_valid(req_valid), .req_length(req_length), .req_ready(req_ready),
    .done(done), .busy(busy), .grant_id(grant_id)
  );

  timer_scheduler #(.NUM_REQ(4), .CNT_WIDTH(4)) dut_s (
    .clock(clock), .sync_reset(sync_reset), .clock_enable(clock_enable),
    .req_valid(req_valid_s), .req_length(req_length_s), .req_ready(req_ready_s),
    .done(done_s), .busy(busy_s), .grant_id(grant_id_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Two reset cycles; the caller's next cyc() is cycle 0 in IDLE.
  task automatic do_reset();
    cyc();
    sync_reset   = 1'b1;
    req_valid    = '0;
    req_valid_s  = '0;
    clock_enable = 1'b0;
    cyc();
  endtask

  initial begin
    // ---------------- reset, with all requests high during reset ----------
    cyc();
    sync_reset = 1'b1;
    req_valid  = 4'b1111;
    cyc();
    #1;
    chk("rst_ready_forced_low", 64'(req_ready), 64'h0);
    cyc();
    sync_reset = 1'b0;
    req_valid  = '0;
    #1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_grant_id", 64'(grant_id), 64'h0);
    chk("rst_count", 64'(dut.count_q), 64'h0);
    chk("rst_len", 64'(dut.len_q), 64'h0);
    chk("rst_ready_idle", 64'(req_ready), 64'h0);

    // ---------------- single request, L=3, continuous ticks ---------------
    do_reset();
    cyc();
    sync_reset   = 1'b0;
    clock_enable = 1'b1;
    req_valid    = 4'b0001;
    req_length[15:0] = 16'd3;
    #1;
    chk("t1_ready_c0", 64'(req_ready), 64'h1);
    for (int c = 1; c <= 6; c++) begin
      cyc();
      req_valid = '0;
      #1;
      chk($sformatf("t1_busy_c%0d", c), 64'(busy), 64'(c <= 5));
      chk($sformatf("t1_done_c%0d", c), 64'(done), (c == 5) ? 64'h1 : 64'h0);
    end

    // ---------------- four requesters back to back, L=0 -------------------
    do_reset();
    cyc();
    sync_reset   = 1'b0;
    clock_enable = 1'b1;
    req_valid    = 4'b1111;
    req_length   = '0;
    for (int c = 0; c <= 14; c++) begin
      if (c > 0) cyc();
      #1;
      chk($sformatf("t2_ready_c%0d", c), 64'(req_ready),
          (c % 3 == 0) ? (64'h1 << ((c / 3) % 4)) : 64'h0);
      chk($sformatf("t2_done_c%0d", c), 64'(done),
          (c % 3 == 2) ? (64'h1 << (((c - 2) / 3) % 4)) : 64'h0);
      if (c % 3 == 1)
        chk($sformatf("t2_grant_c%0d", c), 64'(grant_id), 64'((c / 3) % 4));
    end

    // ---------------- toggling tick enable, requester 2, L=2 --------------
    do_reset();
    cyc();
    sync_reset   = 1'b0;
    req_valid    = 4'b0100;
    req_length   = '0;
    req_length[47:32] = 16'd2;
    #1;
    chk("t3_ready_c0", 64'(req_ready), 64'h4);
    for (int c = 1; c <= 7; c++) begin
      cyc();
      req_valid    = '0;
      clock_enable = c[0];
      #1;
      chk($sformatf("t3_busy_c%0d", c), 64'(busy), 64'(c <= 6));
      chk($sformatf("t3_done_c%0d", c), 64'(done), (c == 6) ? 64'h4 : 64'h0);
      // count seen during cycles 1..5 is 0,1,1,2,2 (holds on low-tick cycles)
      if (c <= 5)
        chk($sformatf("t3_count_c%0d", c), 64'(dut.count_q), 64'(c / 2));
    end

    // ---------------- reset mid-interval ----------------------------------
    // Requester 1 first completes once (last_grant becomes 1), then is granted
    // a long interval that is aborted; afterwards 1 must beat 3.
    do_reset();
    cyc();
    sync_reset   = 1'b0;
    clock_enable = 1'b1;
    req_valid    = 4'b0010;
    req_length   = '0;
    #1;
    chk("t4_ready_c0", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    cyc();
    #1;
    chk("t4_done_c2", 64'(done), 64'h2);
    cyc();
    req_valid = 4'b0010;
    req_length[31:16] = 16'd10;
    #1;
    chk("t4_ready_c3", 64'(req_ready), 64'h2);
    for (int c = 4; c <= 6; c++) begin
      cyc();
      req_valid = '0;
    end
    cyc();
    sync_reset = 1'b1;
    #1;
    chk("t4_count_c7", 64'(dut.count_q), 64'h3);
    chk("t4_busy_c7", 64'(busy), 64'h1);
    cyc();
    sync_reset = 1'b0;
    req_valid  = 4'b1010;
    #1;
    chk("t4_busy_after_rst", 64'(busy), 64'h0);
    chk("t4_count_after_rst", 64'(dut.count_q), 64'h0);
    chk("t4_done_after_rst", 64'(done), 64'h0);
    chk("t4_ready_after_rst", 64'(req_ready), 64'h2);
    cyc();
    req_valid = '0;
    #1;
    chk("t4_grant_after_rst", 64'(grant_id), 64'h1);
    chk("t4_done_none", 64'(done), 64'h0);

    // ---------------- maximum length, CNT_WIDTH=4, L=15 -------------------
    do_reset();
    cyc();
    sync_reset   = 1'b0;
    clock_enable = 1'b1;
    req_valid_s  = 4'b0001;
    req_length_s = 16'h000F;
    #1;
    chk("t5_ready_c0", 64'(req_ready_s), 64'h1);
    for (int c = 1; c <= 18; c++) begin
      cyc();
      req_valid_s = '0;
      #1;
      chk($sformatf("t5_done_c%0d", c), 64'(done_s), (c == 17) ? 64'h1 : 64'h0);
      chk($sformatf("t5_busy_c%0d", c), 64'(busy_s), 64'(c <= 17));
      if (c <= 16)
        chk($sformatf("t5_count_c%0d", c), 64'(dut_s.count_q), 64'(c - 1));
    end

    // ---------------- inputs ignored during RUN, requester 3, L=2 ---------
    do_reset();
    cyc();
    sync_reset   = 1'b0;
    clock_enable = 1'b1;
    req_valid    = 4'b1000;
    req_length   = '0;
    req_length[63:48] = 16'd2;
    #1;
    chk("t6_ready_c0", 64'(req_ready), 64'h8);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      req_valid  = 4'b0111;
      req_length = {16'd15, 16'd9, 16'd9, 16'd9};
      #1;
      if (c <= 3)
        chk($sformatf("t6_ready_run_c%0d", c), 64'(req_ready), 64'h0);
      chk($sformatf("t6_done_c%0d", c), 64'(done), (c == 4) ? 64'h8 : 64'h0);
    end
    cyc();
    #1;
    chk("t6_ready_next_idle", 64'(req_ready), 64'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/timer_scheduler.md
# timer_scheduler

Round-robin scheduler that shares one interval counter among `NUM_REQ` requesters. Each requester asks for a delay of programmable length. The block grants the counter to one requester at a time, times the interval on `clock_enable` ticks, and returns a one-cycle `done` pulse to the owner. It sits between the per-channel sequencing logic (power-up, relay settle, calibration wait) and a single timing resource, so the design needs only one counter.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; legal range ≥ 2.
- `CNT_WIDTH`, 16: width of the interval counter and of each length field.

Ports:
- `clock`  in  1  single system clock; all logic is on its rising edge.
- `sync_reset`  in  1  synchronous, active-high reset; has priority over every other input.
- `clock_enable`  in  1  timer tick qualifier; the counter advances only on cycles where this is high.
- `req_valid`  in  `NUM_REQ`  per-requester request; stays high until accepted.
- `req_length`  in  `NUM_REQ*CNT_WIDTH`  per-requester terminal count; requester i uses bits [i*CNT_WIDTH +: CNT_WIDTH].
- `req_ready`  out  `NUM_REQ`  one-hot accept; combinational.
- `done`  out  `NUM_REQ`  one-cycle completion pulse to the owner; registered.
- `busy`  out  1  high while in RUN or DONE.
- `grant_id`  out  `$clog2(NUM_REQ)`  index of the current or most recent owner.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- **IDLE**
  - Search starts at `(last_grant+1) mod NUM_REQ` and ascends cyclically.
  - The first requester with `req_valid=1` is selected, and `req_ready` is high for it only.
  - On transfer (valid & ready):
    - latch `req_length` of the selected requester into `len_q`;
    - set `count<=0` and `grant_id<=i`;
    - go to RUN.
  - With no valid request, stay in IDLE; `req_ready` is all zero.
- **RUN**
  - On cycles with `clock_enable=1`: if `count==len_q`, go to DONE; otherwise `count<=count+1`.
  - On cycles with `clock_enable=0`: `count` holds and the state holds.
  - The interval is `len_q+1` ticks. `len_q=0` gives one tick; `len_q=2^CNT_WIDTH-1` completes with no wrap.
  - `req_ready` is all zero.
  - Changes to `req_valid` or `req_length` are ignored, including the owner dropping valid.
- **DONE**
  - `done[grant_id]=1` for exactly this cycle.
  - `last_grant<=grant_id`; go to IDLE.
  - DONE is not gated by `clock_enable`.
- Fairness: a requester held valid waits at most `NUM_REQ-1` other grants.
- Reset values:
  - state IDLE; `count=0`; `len_q=0`; `grant_id=0`;
  - `last_grant=NUM_REQ-1`, so requester 0 has first priority;
  - `done=0`; `busy=0`; `req_ready=0`.
  - `req_ready` is forced low while `sync_reset=1`.

## Timing
- Accept occurs in IDLE cycle t.
- RUN is entered at t+1 with `count=0`.
- With `clock_enable` held high:
  - RUN occupies t+1 … t+L+1;
  - `done` pulses at t+L+2;
  - the earliest next accept is t+L+3.
  - Grant period is L+3 cycles.
- `busy` rises at t+1 and falls at t+L+3 (low in the IDLE cycle).
- `sync_reset` in any state: the next cycle is IDLE with reset values.
  - No `done` is issued for an aborted interval.
  - `last_grant` returns to `NUM_REQ-1`.
- A `sync_reset` asserted in the same cycle as an IDLE transfer wins; the transfer is discarded.
- `req_valid` high in the DONE cycle is not accepted until the following IDLE cycle.

## Test plan
- **Single request, continuous ticks.** `NUM_REQ=4`; `req_valid[0]=1` with `req_length[0]=3` at cycle 0; `clock_enable=1` throughout.
  - `req_ready=4'b0001` at cycle 0.
  - `busy` high in cycles 1–5.
  - `done=4'b0001` only at cycle 5; IDLE at cycle 6.
- **All four requesters, back to back.** All `req_valid` high continuously; every `req_length=0`; `clock_enable=1`.
  - Grants occur in order 0,1,2,3,0 at cycles 0,3,6,9,12.
  - `done[i]` follows each grant by 2 cycles.
- **Toggling tick enable.** `req_length[2]=2`; `clock_enable` alternates 1,0,1,0… starting in the first RUN cycle.
  - `count` holds on low cycles.
  - RUN spans cycles 1–5; `done[2]` at cycle 6.
- **Reset mid-interval.** `req_length[1]=10`; assert `sync_reset` for 1 cycle at RUN cycle 4.
  - No `done` pulse.
  - `busy=0` and `count=0` in the next cycle.
  - With requesters 1 and 3 both valid afterwards, requester 1 wins (priority restarted at 0).
- **Maximum length, no wrap.** Override `CNT_WIDTH=4`; `req_length[0]=15`.
  - `done[0]` at cycle 17; `count` never wraps to 0 before DONE.
- **Inputs ignored during RUN.** Owner drops `req_valid` and changes `req_length` during RUN.
  - The interval still completes with the latched length.
  - `done` still pulses to the owner.
  - `req_ready` stays zero throughout RUN.
